// File: rtl/key_bank.sv
`default_nettype none
// ============================================================================
// Module   : key_bank
// Purpose  : Multi-slot key store. Keys are loaded in order over a valid/ready
//            stream and played back one per step, in forward or reverse order.
//            Optional macro KEY_PARITY_CHECK_EN rejects keys without odd byte parity.
// Revision : 1.0 - initial release
// ============================================================================
module key_bank #(
    parameter  int KEY_W    = 64,
    parameter  int NUM_KEYS = 3,
    localparam int PTR_W    = $clog2(NUM_KEYS)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      load_valid,
    input  logic [KEY_W-1:0]          load_key,
    output logic                      load_ready,
    input  logic                      clear,
    output logic                      keys_valid,
    input  logic                      seq_start,
    input  logic                      seq_decrypt,
    input  logic                      seq_next,
    output logic                      seq_active,
    output logic [PTR_W-1:0]          seq_idx,
    output logic [KEY_W-1:0]          seq_key,
    output logic                      seq_done,
    output logic [NUM_KEYS*KEY_W-1:0] key_flat,
    output logic                      parity_err
);

    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NUM_KEYS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic [KEY_W-1:0] r_slots [NUM_KEYS];
    logic [PTR_W-1:0] r_wr_ptr;
    logic             r_keys_valid;

    state_t           r_state,   w_state_nxt;
    logic [PTR_W-1:0] r_seq_idx, w_idx_nxt;
    logic             r_dir,     w_dir_nxt;
    logic             r_seq_done, w_done_nxt;

    logic w_key_ok;
    logic w_take;
    logic w_accept;
    logic w_last;

    assign load_ready = !r_keys_valid;
    assign keys_valid = r_keys_valid;
    assign w_take     = load_valid && load_ready && !clear;
    assign w_accept   = w_take && w_key_ok;

`ifdef KEY_PARITY_CHECK_EN
    logic [KEY_W/8-1:0] w_byte_odd;
    logic               r_parity_err;

    for (genvar b = 0; b < KEY_W/8; b++) begin : g_byte_parity
        assign w_byte_odd[b] = ^load_key[b*8 +: 8];
    end
    assign w_key_ok   = &w_byte_odd;
    assign parity_err = r_parity_err;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_parity_err <= 1'b0;
        else        r_parity_err <= w_take && !w_key_ok;
    end
`else
    assign w_key_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Slot storage and write pointer; clear outranks any load in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_KEYS; i++) r_slots[i] <= '0;
            r_wr_ptr     <= '0;
            r_keys_valid <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NUM_KEYS; i++) r_slots[i] <= '0;
            r_wr_ptr     <= '0;
            r_keys_valid <= 1'b0;
        end else if (w_accept) begin
            r_slots[r_wr_ptr] <= load_key;
            if (r_wr_ptr == c_last_idx) begin
                r_wr_ptr     <= '0;
                r_keys_valid <= 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_flat
        assign key_flat[i*KEY_W +: KEY_W] = r_slots[i];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_seq_idx  <= '0;
            r_dir      <= 1'b0;
            r_seq_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seq_idx  <= w_idx_nxt;
            r_dir      <= w_dir_nxt;
            r_seq_done <= w_done_nxt;
        end
    end

    assign w_last = r_dir ? (r_seq_idx == '0) : (r_seq_idx == c_last_idx);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_seq_idx;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // keys_valid is the registered flag, so a last-key load in
                    // this cycle cannot start a sequence yet.
                    if (seq_start && r_keys_valid) begin
                        w_state_nxt = S_RUN;
                        w_dir_nxt   = seq_decrypt;
                        w_idx_nxt   = seq_decrypt ? c_last_idx : '0;
                    end
                end
                S_RUN: begin
                    if (seq_next) begin
                        if (w_last) begin
                            w_state_nxt = S_IDLE;
                            w_idx_nxt   = '0;
                            w_done_nxt  = 1'b1;
                        end else if (r_dir) begin
                            w_idx_nxt = r_seq_idx - 1'b1;
                        end else begin
                            w_idx_nxt = r_seq_idx + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign seq_active = (r_state == S_RUN);
    assign seq_idx    = r_seq_idx;
    assign seq_done   = r_seq_done;
    assign seq_key    = seq_active ? r_slots[r_seq_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_key_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_bank
// Purpose  : Scoreboard bench for key_bank against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_bank;

    localparam int KEY_W = 64;
    localparam int N     = 3;
    localparam int PW    = 2;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              load_valid = 1'b0;
    logic [KEY_W-1:0]  load_key = '0;
    logic              load_ready;
    logic              clear = 1'b0;
    logic              keys_valid;
    logic              seq_start = 1'b0;
    logic              seq_decrypt = 1'b0;
    logic              seq_next = 1'b0;
    logic              seq_active;
    logic [PW-1:0]     seq_idx;
    logic [KEY_W-1:0]  seq_key;
    logic              seq_done;
    logic [N*KEY_W-1:0] key_flat;
    logic              parity_err;

    key_bank #(.KEY_W(KEY_W), .NUM_KEYS(N)) dut (
        .clk(clk), .n_rst(n_rst),
        .load_valid(load_valid), .load_key(load_key), .load_ready(load_ready),
        .clear(clear), .keys_valid(keys_valid),
        .seq_start(seq_start), .seq_decrypt(seq_decrypt), .seq_next(seq_next),
        .seq_active(seq_active), .seq_idx(seq_idx), .seq_key(seq_key),
        .seq_done(seq_done), .key_flat(key_flat), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              ready;
        logic              kv;
        logic              act;
        logic [PW-1:0]     idx;
        logic [KEY_W-1:0]  key;
        logic              done;
        logic [N*KEY_W-1:0] flat;
        logic              perr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: slots filled by a count, playback from an explicit order list.
    logic [KEY_W-1:0] m_slots [N];
    int               m_n;
    bit               m_run;
    int               m_order [$];
    int               m_pos;
    bit               m_done;
    bit               m_perr;

`ifdef KEY_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    function automatic bit odd_bytes(logic [KEY_W-1:0] k);
        for (int b = 0; b < KEY_W/8; b++)
            if ($countones(k[b*8 +: 8]) % 2 == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [KEY_W-1:0] make_odd(logic [KEY_W-1:0] k);
        logic [KEY_W-1:0] r;
        r = k;
        for (int b = 0; b < KEY_W/8; b++)
            if ($countones(r[b*8 +: 8]) % 2 == 0) r[b*8] = ~r[b*8];
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_slots[i] = '0;
        m_n = 0; m_run = 0; m_pos = 0; m_done = 0; m_perr = 0;
        m_order.delete();
    endfunction

    function automatic void model_step(bit v, logic [KEY_W-1:0] k, bit clr,
                                       bit st, bit dec, bit nx);
        bit full_before;
        full_before = (m_n == N);
        m_done = 0;
        m_perr = 0;
        if (clr) begin
            for (int i = 0; i < N; i++) m_slots[i] = '0;
            m_n = 0;
            m_run = 0;
            m_order.delete();
            return;
        end
        if (v && m_n < N) begin
            if (!PCHK || odd_bytes(k)) begin
                m_slots[m_n] = k;
                m_n++;
            end else begin
                m_perr = 1;
            end
        end
        if (!m_run) begin
            if (st && full_before) begin
                m_run = 1;
                m_pos = 0;
                m_order.delete();
                for (int i = 0; i < N; i++) m_order.push_back(dec ? N-1-i : i);
            end
        end else if (nx) begin
            m_pos++;
            if (m_pos == N) begin
                m_run  = 0;
                m_done = 1;
            end
        end
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.ready = (m_n < N);
        e.kv    = (m_n == N);
        e.act   = m_run;
        e.idx   = m_run ? PW'(m_order[m_pos]) : '0;
        e.key   = m_run ? m_slots[m_order[m_pos]] : '0;
        e.done  = m_done;
        e.flat  = {m_slots[2], m_slots[1], m_slots[0]};
        e.perr  = m_perr;
        return e;
    endfunction

    task automatic cycle(bit v, logic [KEY_W-1:0] k, bit clr, bit st, bit dec, bit nx);
        @(negedge clk);
        n_rst = 1'b1;
        load_valid = v; load_key = k; clear = clr;
        seq_start = st; seq_decrypt = dec; seq_next = nx;
        model_step(v, k, clr, st, dec, nx);
        exp_q.push_back(snapshot());
    endtask

    task automatic idle();
        cycle(0, '0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        load_valid = 0; clear = 0; seq_start = 0; seq_next = 0;
        model_reset();
        exp_q.push_back(snapshot());
    endtask

    task automatic chk(string name, logic [N*KEY_W-1:0] act, logic [N*KEY_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected snapshot per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("load_ready", N*KEY_W'(load_ready), N*KEY_W'(e.ready));
                chk("keys_valid", N*KEY_W'(keys_valid), N*KEY_W'(e.kv));
                chk("seq_active", N*KEY_W'(seq_active), N*KEY_W'(e.act));
                if (e.act) chk("seq_idx", N*KEY_W'(seq_idx), N*KEY_W'(e.idx));
                chk("seq_key", N*KEY_W'(seq_key), N*KEY_W'(e.key));
                chk("seq_done", N*KEY_W'(seq_done), N*KEY_W'(e.done));
                chk("key_flat", key_flat, e.flat);
                chk("parity_err", N*KEY_W'(parity_err), N*KEY_W'(e.perr));
            end
        end
    end

    localparam logic [KEY_W-1:0] K1  = 64'h0123456789ABCDEF;
    localparam logic [KEY_W-1:0] K2  = 64'h23456789ABCDEF01;
    localparam logic [KEY_W-1:0] K3  = 64'h456789ABCDEF0123;
    localparam logic [KEY_W-1:0] BAD = 64'h0123456789ABCDEE;

    initial begin
        logic [KEY_W-1:0] rk;
        model_reset();
        do_reset();
        idle();

        cycle(1, K1, 0, 0, 0, 0);
        cycle(1, K2, 0, 0, 0, 0);
        cycle(1, K3, 0, 0, 0, 0);
        idle();
        cycle(1, K1, 0, 0, 0, 0);              // refused while full

        cycle(0, '0, 0, 1, 0, 0);              // encrypt order
        for (int i = 0; i < 3; i++) begin
            idle();
            cycle(0, '0, 0, 0, 0, 1);
        end
        idle();

        cycle(0, '0, 0, 1, 1, 0);              // decrypt order
        cycle(0, '0, 0, 1, 0, 1);              // start while running ignored
        cycle(0, '0, 0, 1, 0, 1);
        cycle(0, '0, 0, 0, 0, 1);
        idle();

        cycle(0, '0, 0, 1, 0, 0);
        cycle(0, '0, 0, 0, 0, 1);              // now at idx 1
        cycle(0, '0, 1, 0, 0, 0);              // clear mid-sequence
        idle();
        cycle(1, K3, 0, 0, 0, 0);
        cycle(1, K1, 0, 0, 0, 0);
        cycle(1, K2, 0, 0, 0, 0);
        idle();

        cycle(0, '0, 1, 0, 0, 0);
        cycle(1, BAD, 0, 0, 0, 0);
        idle();
        cycle(1, K2, 0, 0, 0, 0);
        idle();

        cycle(0, '0, 1, 0, 0, 0);              // last load with seq_start
        cycle(1, K1, 0, 0, 0, 0);
        cycle(1, K2, 0, 0, 0, 0);
        cycle(1, K3, 0, 1, 0, 0);
        idle();
        cycle(0, '0, 0, 1, 1, 0);
        cycle(0, '0, 0, 0, 0, 1);
        do_reset();                            // reset mid-sequence
        idle();

        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) < 1) begin
                do_reset();
            end else begin
                rk = {$urandom, $urandom};
                if ($urandom_range(0, 99) < 80) rk = make_odd(rk);
                cycle($urandom_range(0, 99) < 40, rk,
                      $urandom_range(0, 99) < 3,
                      $urandom_range(0, 99) < 25,
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 99) < 45);
            end
        end
        idle();

        repeat (4) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
